uart_rx: RTL and testbench

//  Receive side of the 8N1 UART link: oversamples the asynchronous serial line with the system

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_sync2.sv | 21 ++
 rtl/uart_rx.sv | 145 ++++++++++++++
 tb/tb_uart_rx.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default bit timing and counter sizing.
package uart_pkg;

    localparam int unsigned CLKS_PER_BIT_DEFAULT = 217;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_STOP    = 3'd3,
        S_CLEANUP = 3'd4
    } uart_state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned clog2_safe(input int unsigned n);
        return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous level; resets to 1 (idle level of a UART line).
module uart_sync2 (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_Async,
    output logic o_Sync
);

    logic meta_q;

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            meta_q <= 1'b1;
            o_Sync <= 1'b1;
        end else begin
            meta_q <= i_Async;
            o_Sync <= meta_q;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled start detect, mid-bit data sampling, stop-bit check.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Active,
    output logic       o_Rx_Frame_Err
);

    localparam int unsigned     CNT_W = clog2_safe(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic             armed_q, armed_d;
    logic [1:0]       flush_q;
    logic             dv_d, ferr_d, active_d;
    logic [7:0]       byte_d;
    logic             rx_s;

    uart_sync2 u_sync (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .i_Async (i_Rx_Serial),
        .o_Sync  (rx_s)
    );

    // Synchronizer resets high; its output is not trusted for arming until real line values reach it.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) flush_q <= 2'b00;
        else         flush_q <= {flush_q[0], 1'b1};
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q        <= S_IDLE;
            clk_cnt_q      <= '0;
            bit_idx_q      <= '0;
            rx_shift_q     <= '0;
            armed_q        <= 1'b0;
            o_Rx_DV        <= 1'b0;
            o_Rx_Byte      <= '0;
            o_Rx_Active    <= 1'b0;
            o_Rx_Frame_Err <= 1'b0;
        end else begin
            state_q        <= state_d;
            clk_cnt_q      <= clk_cnt_d;
            bit_idx_q      <= bit_idx_d;
            rx_shift_q     <= rx_shift_d;
            armed_q        <= armed_d;
            o_Rx_DV        <= dv_d;
            o_Rx_Byte      <= byte_d;
            o_Rx_Active    <= active_d;
            o_Rx_Frame_Err <= ferr_d;
        end
    end

    // Next-state and output logic; strobes default low so they last one cycle.
    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_idx_d  = bit_idx_q;
        rx_shift_d = rx_shift_q;
        armed_d    = armed_q;
        dv_d       = 1'b0;
        ferr_d     = 1'b0;
        byte_d     = o_Rx_Byte;
        active_d   = o_Rx_Active;

        case (state_q)
            S_IDLE: begin
                clk_cnt_d = '0;
                bit_idx_d = '0;
                if (!rx_s && armed_q) begin
                    state_d  = S_START;
                    active_d = 1'b1;
                    armed_d  = 1'b0;
                end else if (rx_s && flush_q[1]) begin
                    armed_d = 1'b1;
                end
            end
            S_START: begin
                if (clk_cnt_q == HALF) begin
                    clk_cnt_d = '0;
                    if (!rx_s) begin
                        state_d = S_DATA;
                    end else begin
                        state_d  = S_IDLE;
                        active_d = 1'b0;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (clk_cnt_q == LAST) begin
                    clk_cnt_d             = '0;
                    rx_shift_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = '0;
                        state_d   = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (clk_cnt_q == LAST) begin
                    clk_cnt_d = '0;
                    if (rx_s) begin
                        byte_d = rx_shift_q;
                        dv_d   = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                    active_d = 1'b0;
                    state_d  = S_CLEANUP;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            S_CLEANUP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                clk_cnt_d = '0;
                bit_idx_d = '0;
                active_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: behavioural serial driver, expected-frame queue, strobe monitor.
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int HALF = (CPB - 1) / 2;
    localparam int LAT  = 2 + HALF + 9 * CPB + 3;

    typedef struct {
        logic       err;
        logic [7:0] data;
        int         t_low;
        bit         lat;
        bit         space;
    } exp_t;

    logic       clk, rst, rx;
    logic       dv, ferr, act;
    logic [7:0] rbyte;

    exp_t       sbq[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_dv_cyc = 0;
    bit         prev_strobe = 0;
    logic [7:0] last_good = 8'h00;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock        (clk),
        .i_Reset        (rst),
        .i_Rx_Serial    (rx),
        .o_Rx_DV        (dv),
        .o_Rx_Byte      (rbyte),
        .o_Rx_Active    (act),
        .o_Rx_Frame_Err (ferr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    // Drive the first n bits of a 10-bit frame (start, data LSB first, stop); call at a negedge.
    task automatic drive_bits(input logic [9:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            rx = f[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input bit lat, input bit space);
        exp_t e;
        e.err   = !stop;
        e.data  = stop ? d : last_good;
        e.t_low = cyc;
        e.lat   = lat;
        e.space = space;
        if (stop) last_good = d;
        sbq.push_back(e);
        drive_bits({stop, d, 1'b0}, 10);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every strobe must match the head of the expected queue.
    always @(negedge clk) begin
        exp_t e;
        int   d;
        if (rst) begin
            prev_strobe = 0;
        end else begin
            if (dv || ferr) begin
                checks++;
                if (dv && ferr) begin
                    errors++;
                    $display("FAIL strobe_excl: dv=%0b ferr=%0b both high", dv, ferr);
                end
                checks++;
                if (prev_strobe) begin
                    errors++;
                    $display("FAIL strobe_width: strobe high two cycles in a row at cycle %0d", cyc);
                end
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: dv=%0b ferr=%0b byte=%02h, none expected", dv, ferr, rbyte);
                end else begin
                    e = sbq.pop_front();
                    checks++;
                    if (ferr !== e.err || dv !== !e.err || rbyte !== e.data) begin
                        errors++;
                        $display("FAIL frame: got dv=%0b ferr=%0b byte=%02h expected dv=%0b ferr=%0b byte=%02h",
                                 dv, ferr, rbyte, !e.err, e.err, e.data);
                    end
                    if (e.lat) begin
                        d = cyc - e.t_low;
                        checks++;
                        if (d < LAT - 1 || d > LAT + 1) begin
                            errors++;
                            $display("FAIL latency: got %0d expected %0d +/-1", d, LAT);
                        end
                    end
                    if (e.space) begin
                        d = cyc - last_dv_cyc;
                        checks++;
                        if (d < 10 * CPB - 1 || d > 10 * CPB + 1) begin
                            errors++;
                            $display("FAIL spacing: got %0d expected %0d +/-1", d, 10 * CPB);
                        end
                    end
                end
                if (dv) last_dv_cyc = cyc;
            end
            prev_strobe = dv || ferr;
        end
    end

    initial begin
        int rise_c, fall_c, bad;
        logic [7:0] b;
        logic       s;

        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_dv", 32'(dv), 32'd0);
        chk("reset_byte", 32'(rbyte), 32'd0);
        chk("reset_active", 32'(act), 32'd0);
        chk("reset_ferr", 32'(ferr), 32'd0);
        rst = 1'b0;
        idle(3 * CPB);

        // Loopback with idle gaps
        send_frame(8'h37, 1'b1, 1, 0); idle(2 * CPB);
        send_frame(8'h00, 1'b1, 1, 0); idle(2 * CPB);
        send_frame(8'hFF, 1'b1, 1, 0); idle(2 * CPB);
        send_frame(8'hA5, 1'b1, 1, 0); idle(2 * CPB);
        chk("t1_queue_empty", 32'(sbq.size()), 32'd0);

        // Short glitch must be rejected at the start-bit midpoint
        rise_c = -1;
        fall_c = -1;
        for (int k = 0; k < 40; k++) begin
            rx = (k < 4) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (act && rise_c < 0) rise_c = k;
            if (!act && rise_c >= 0 && fall_c < 0) fall_c = k;
        end
        chk("glitch_active_seen", 32'(rise_c >= 0), 32'd1);
        chk("glitch_active_drop", 32'(fall_c >= 0 && fall_c - rise_c <= HALF + 3), 32'd1);
        idle(CPB);

        // Framing error followed by a held-low break
        send_frame(8'h5A, 1'b1, 1, 0); idle(CPB);
        send_frame(8'h55, 1'b0, 1, 0);
        rx  = 1'b0;
        bad = 0;
        for (int k = 0; k < 39 * CPB; k++) begin
            @(negedge clk);
            if (act) bad++;
        end
        chk("break_no_activity", 32'(bad), 32'd0);
        chk("ferr_byte_held", 32'(rbyte), 32'h5A);
        idle(2 * CPB);
        send_frame(8'h3C, 1'b1, 1, 0); idle(2 * CPB);
        chk("t3_queue_empty", 32'(sbq.size()), 32'd0);

        // Asynchronous reset during data bit 4
        drive_bits({1'b1, 8'h81, 1'b0}, 5);
        rx = 1'b0;
        repeat (8) @(negedge clk);
        chk("pre_reset_active", 32'(act), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midreset_outputs", {22'd0, act, dv, ferr, rbyte}, 32'd0);
        last_good = 8'h00;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(2 * CPB);
        send_frame(8'hC3, 1'b1, 1, 0); idle(2 * CPB);
        chk("t4_queue_empty", 32'(sbq.size()), 32'd0);

        // Back-to-back frames with zero idle
        send_frame(8'h12, 1'b1, 1, 0);
        send_frame(8'h34, 1'b1, 1, 1);
        send_frame(8'h56, 1'b1, 1, 1);
        idle(2 * CPB);
        chk("t5_queue_empty", 32'(sbq.size()), 32'd0);

        // Randomized frames; an errored frame gets at least one bit of idle to re-arm
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom);
            s = ($urandom_range(0, 4) != 0);
            send_frame(b, s, 1, 0);
            idle(s ? $urandom_range(0, 3 * CPB) : CPB + $urandom_range(0, 2 * CPB));
        end
        idle(2 * CPB);
        chk("rand_queue_empty", 32'(sbq.size()), 32'd0);

        // Line low across reset release must not start a frame
        rx  = 1'b0;
        rst = 1'b1;
        last_good = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (act) bad++;
        end
        chk("low_after_reset_no_start", 32'(bad), 32'd0);
        idle(20);
        send_frame(8'h99, 1'b1, 1, 0);
        idle(2 * CPB);
        chk("t6_queue_empty", 32'(sbq.size()), 32'd0);
        chk("t6_byte", 32'(rbyte), 32'h99);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
